// File: rtl/decimal_entry.sv
// Keypad-style decimal entry: buffers up to DIGITS BCD digits, converts them to binary, range-checks.
// Optional macro DECIMAL_ENTRY_CLAMP_EN: clamp out-of-range results to min/max instead of rejecting.
module decimal_entry #(
  parameter int unsigned W_OUT  = 8,
  parameter int unsigned DIGITS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             digit_valid,
  input  logic [3:0]                       digit,
  output logic                             digit_ready,
  input  logic                             backspace,
  input  logic                             enter,
  input  logic                             cancel,
  input  logic [W_OUT-1:0]                 min_value,
  input  logic [W_OUT-1:0]                 max_value,
  output logic                             busy,
  output logic [$clog2(DIGITS+1)-1:0]      count,
  output logic [DIGITS-1:0][3:0]           digits_out,
  output logic [W_OUT-1:0]                 value,
  output logic                             value_valid,
  output logic                             error
);

  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned AW = W_OUT + 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    CONVERT = 2'd2,
    CHECK   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [DIGITS-1:0][3:0]  digits_q, digits_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [W_OUT-1:0]        value_q, value_d;
  logic                    vv_q, vv_d;
  logic                    err_q, err_d;

  logic                    ready;
  logic [3:0]              cur_digit;
  logic [AW-1:0]           acc_mac;
  logic                    above;
  logic                    below;

  assign ready       = (state_q == ENTRY) && (count_q < CW'(DIGITS));
  assign digit_ready = ready;
  assign busy        = (state_q != IDLE);
  assign count       = count_q;
  assign digits_out  = digits_q;
  assign value       = value_q;
  assign value_valid = vv_q;
  assign error       = err_q;

  // Digit under conversion, most significant first (idx counts down to 0)
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == CW'(i)) cur_digit = digits_q[i];
    end
  end

  // acc*10 + digit; the accumulator never exceeds 2^W_OUT-1 before this step unless ovf is already set
  assign acc_mac = {acc_q[AW-4:0], 3'b000} + {acc_q[AW-2:0], 1'b0} + AW'(cur_digit);
  assign above   = ovf_q || (acc_q > AW'(max_value));
  assign below   = (acc_q < AW'(min_value));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    digits_d = digits_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    value_d  = value_q;
    vv_d     = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ENTRY;
          count_d  = '0;
          digits_d = '0;
        end
      end

      ENTRY: begin
        if (cancel) begin
          state_d  = IDLE;
          count_d  = '0;
          digits_d = '0;
        end else if (start) begin
          count_d  = '0;
          digits_d = '0;
        end else if (enter) begin
          if (count_q == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = CONVERT;
            acc_d   = '0;
            ovf_d   = 1'b0;
            idx_d   = count_q - CW'(1);
          end
        end else if (backspace) begin
          if (count_q != '0) begin
            for (int i = 0; i < int'(DIGITS) - 1; i++) digits_d[i] = digits_q[i+1];
            digits_d[DIGITS-1] = 4'd0;
            count_d = count_q - CW'(1);
          end
        end else if (digit_valid && ready) begin
          if (digit > 4'd9) begin
            err_d = 1'b1;
          end else begin
            for (int i = int'(DIGITS) - 1; i > 0; i--) digits_d[i] = digits_q[i-1];
            digits_d[0] = digit;
            count_d = count_q + CW'(1);
          end
        end
      end

      CONVERT: begin
        if (cancel) begin
          state_d  = IDLE;
          count_d  = '0;
          digits_d = '0;
        end else begin
          acc_d = acc_mac;
          if (acc_mac[AW-1:W_OUT] != '0) ovf_d = 1'b1;
          if (idx_q == '0) state_d = CHECK;
          else             idx_d   = idx_q - CW'(1);
        end
      end

      CHECK: begin
        if (cancel) begin
          state_d  = IDLE;
          count_d  = '0;
          digits_d = '0;
        end else if (!above && !below) begin
          value_d = acc_q[W_OUT-1:0];
          vv_d    = 1'b1;
          state_d = IDLE;
        end else begin
`ifdef DECIMAL_ENTRY_CLAMP_EN
          value_d = above ? max_value : min_value;
          vv_d    = 1'b1;
          state_d = IDLE;
`else
          err_d   = 1'b1;
          state_d = ENTRY;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      digits_q <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      value_q  <= '0;
      vv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      digits_q <= digits_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      value_q  <= value_d;
      vv_q     <= vv_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_decimal_entry.sv
// Directed table-driven bench for decimal_entry (W_OUT=8, DIGITS=2), plus reset-during-convert sequence.
module tb_decimal_entry;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, digit_valid, backspace, enter, cancel;
  logic [3:0]      digit;
  logic [7:0]      min_value, max_value;
  logic            digit_ready, busy, value_valid, error;
  logic [1:0]      count;
  logic [1:0][3:0] digits_out;
  logic [7:0]      value;

  int checks = 0;
  int errors = 0;

  decimal_entry #(.W_OUT(8), .DIGITS(2)) dut (
    .clk(clk), .rst(rst), .start(start), .digit_valid(digit_valid), .digit(digit),
    .digit_ready(digit_ready), .backspace(backspace), .enter(enter), .cancel(cancel),
    .min_value(min_value), .max_value(max_value), .busy(busy), .count(count),
    .digits_out(digits_out), .value(value), .value_valid(value_valid), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, dv;
    logic [3:0] dg;
    logic       bs, en, cn;
    logic [7:0] mn, mx;
    logic       e_busy;
    logic [1:0] e_cnt;
    logic [7:0] e_dig;
    logic [7:0] e_val;
    logic       e_vv, e_err, e_rdy;
    logic       ck_cnt, ck_dig;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] cur_mn, cur_mx;

  task automatic add(input logic st, dv, input logic [3:0] dg, input logic bs, en, cn,
                     input logic e_busy, input logic [1:0] e_cnt, input logic [7:0] e_dig,
                     input logic [7:0] e_val, input logic e_vv, e_err, e_rdy, ck_cnt, ck_dig);
    vec_t v;
    v.st = st; v.dv = dv; v.dg = dg; v.bs = bs; v.en = en; v.cn = cn;
    v.mn = cur_mn; v.mx = cur_mx;
    v.e_busy = e_busy; v.e_cnt = e_cnt; v.e_dig = e_dig; v.e_val = e_val;
    v.e_vv = e_vv; v.e_err = e_err; v.e_rdy = e_rdy; v.ck_cnt = ck_cnt; v.ck_dig = ck_dig;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, dv, input logic [3:0] dg, input logic bs, en, cn);
    start = st; digit_valid = dv; digit = dg; backspace = bs; enter = en; cancel = cn;
  endtask

  logic [7:0] lv;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    min_value = 8'd0;
    max_value = 8'd0;

    // Build vector table (inputs applied for one cycle, outputs checked #1 after the edge)
    cur_mn = 8'd1; cur_mx = 8'd21;
    add(1,0,0,0,0,0, 1,0,8'h00, 0,0,0,1, 1,1);
    add(0,1,2,0,0,0, 1,1,8'h02, 0,0,0,1, 1,1);
    add(0,1,1,0,0,0, 1,2,8'h21, 0,0,0,0, 1,1);
    add(0,0,0,0,1,0, 1,2,8'h21, 0,0,0,0, 1,1);
    add(0,0,0,0,0,0, 1,2,8'h21, 0,0,0,0, 1,1);
    add(0,0,0,0,0,0, 1,2,8'h21, 0,0,0,0, 1,1);
    add(0,0,0,0,0,0, 0,0,8'h00, 21,1,0,0, 0,0);
    add(0,0,0,0,0,0, 0,0,8'h00, 21,0,0,0, 0,0);
    add(1,0,0,0,0,0, 1,0,8'h00, 21,0,0,1, 1,1);
    add(0,1,2,0,0,0, 1,1,8'h02, 21,0,0,1, 1,1);
    add(0,1,5,0,0,0, 1,2,8'h25, 21,0,0,0, 1,1);
    add(0,0,0,0,1,0, 1,2,8'h25, 21,0,0,0, 1,1);
    add(0,0,0,0,0,0, 1,2,8'h25, 21,0,0,0, 1,1);
    add(0,0,0,0,0,0, 1,2,8'h25, 21,0,0,0, 1,1);
`ifdef DECIMAL_ENTRY_CLAMP_EN
    add(0,0,0,0,0,0, 0,0,8'h00, 21,1,0,0, 0,0);
    add(0,0,0,0,0,0, 0,0,8'h00, 21,0,0,0, 0,0);
`else
    add(0,0,0,0,0,0, 1,2,8'h25, 21,0,1,0, 1,1);
    add(0,0,0,0,0,0, 1,2,8'h25, 21,0,0,0, 1,1);
`endif
    cur_mn = 8'd0; cur_mx = 8'd99;
    add(1,0,0,0,0,0, 1,0,8'h00, 21,0,0,1, 1,1);
    add(0,1,4,0,0,0, 1,1,8'h04, 21,0,0,1, 1,1);
    add(0,1,7,0,0,0, 1,2,8'h47, 21,0,0,0, 1,1);
    add(0,0,0,1,0,0, 1,1,8'h04, 21,0,0,1, 1,1);
    add(0,1,3,0,0,0, 1,2,8'h43, 21,0,0,0, 1,1);
    add(0,1,8,0,0,0, 1,2,8'h43, 21,0,0,0, 1,1);
    add(0,0,0,0,1,0, 1,2,8'h43, 21,0,0,0, 1,1);
    add(0,0,0,0,0,0, 1,2,8'h43, 21,0,0,0, 1,1);
    add(0,0,0,0,0,0, 1,2,8'h43, 21,0,0,0, 1,1);
    add(0,0,0,0,0,0, 0,0,8'h00, 43,1,0,0, 0,0);
    add(0,0,0,0,0,0, 0,0,8'h00, 43,0,0,0, 0,0);
    add(1,0,0,0,0,0, 1,0,8'h00, 43,0,0,1, 1,1);
    add(0,0,0,0,1,0, 1,0,8'h00, 43,0,1,1, 1,1);
    add(0,1,12,0,0,0, 1,0,8'h00, 43,0,1,1, 1,1);
    add(0,0,0,0,0,0, 1,0,8'h00, 43,0,0,1, 1,1);
    add(0,1,5,0,0,0, 1,1,8'h05, 43,0,0,1, 1,1);
    add(0,1,7,1,0,0, 1,0,8'h00, 43,0,0,1, 1,1);
    add(0,1,3,1,1,0, 1,0,8'h00, 43,0,1,1, 1,1);
    add(0,1,9,0,0,0, 1,1,8'h09, 43,0,0,1, 1,1);
    add(0,0,0,0,1,1, 0,0,8'h00, 43,0,0,0, 1,0);
    add(0,0,0,0,0,0, 0,0,8'h00, 43,0,0,0, 1,0);
    cur_mn = 8'd50; cur_mx = 8'd99;
    add(1,0,0,0,0,0, 1,0,8'h00, 43,0,0,1, 1,1);
    add(0,1,1,0,0,0, 1,1,8'h01, 43,0,0,1, 1,1);
    add(0,0,0,0,1,0, 1,1,8'h01, 43,0,0,0, 1,1);
    add(0,0,0,0,0,0, 1,1,8'h01, 43,0,0,0, 1,1);
`ifdef DECIMAL_ENTRY_CLAMP_EN
    add(0,0,0,0,0,0, 0,0,8'h00, 50,1,0,0, 0,0);
    add(0,0,0,0,0,0, 0,0,8'h00, 50,0,0,0, 0,0);
    lv = 8'd50;
`else
    add(0,0,0,0,0,0, 1,1,8'h01, 43,0,1,1, 1,1);
    add(0,0,0,0,0,0, 1,1,8'h01, 43,0,0,1, 1,1);
    lv = 8'd43;
`endif
    add(1,0,0,0,0,0, 1,0,8'h00, lv,0,0,1, 1,1);
    add(0,1,8,0,0,0, 1,1,8'h08, lv,0,0,1, 1,1);
    add(0,0,0,0,1,0, 1,1,8'h08, lv,0,0,0, 1,1);
    add(0,0,0,0,0,1, 0,0,8'h00, lv,0,0,0, 1,0);
    add(0,0,0,0,0,0, 0,0,8'h00, lv,0,0,0, 1,0);
    add(0,0,0,0,0,0, 0,0,8'h00, lv,0,0,0, 1,0);

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy",  32'(digit_ready), 32'd0);
    chk("rst_cnt",  32'(count), 32'd0);
    chk("rst_dig",  32'(digits_out), 32'd0);
    chk("rst_val",  32'(value), 32'd0);
    chk("rst_vv",   32'(value_valid), 32'd0);
    chk("rst_err",  32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].dv, vecs[i].dg, vecs[i].bs, vecs[i].en, vecs[i].cn);
      min_value = vecs[i].mn;
      max_value = vecs[i].mx;
      @(posedge clk);
      #1;
      chk($sformatf("r%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("r%0d_rdy", i),  32'(digit_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("r%0d_val", i),  32'(value), 32'(vecs[i].e_val));
      chk($sformatf("r%0d_vv", i),   32'(value_valid), 32'(vecs[i].e_vv));
      chk($sformatf("r%0d_err", i),  32'(error), 32'(vecs[i].e_err));
      if (vecs[i].ck_cnt) chk($sformatf("r%0d_cnt", i), 32'(count), 32'(vecs[i].e_cnt));
      if (vecs[i].ck_dig) chk($sformatf("r%0d_dig", i), 32'(digits_out), 32'(vecs[i].e_dig));
    end

    // Reset asserted mid-CONVERT: everything clears at once, no pulse afterwards
    min_value = 8'd0;
    max_value = 8'd99;
    drive(1, 0, 0, 0, 0, 0); @(posedge clk); #1;
    drive(0, 1, 9, 0, 0, 0); @(posedge clk); #1;
    drive(0, 1, 9, 0, 0, 0); @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 0); @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rdy",  32'(digit_ready), 32'd0);
    chk("arst_cnt",  32'(count), 32'd0);
    chk("arst_dig",  32'(digits_out), 32'd0);
    chk("arst_val",  32'(value), 32'd0);
    chk("arst_vv",   32'(value_valid), 32'd0);
    chk("arst_err",  32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst%0d_vv", k),   32'(value_valid), 32'd0);
      chk($sformatf("post_rst%0d_err", k),  32'(error), 32'd0);
      chk($sformatf("post_rst%0d_busy", k), 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
